// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, runs a req/ready handshake
//            to a variable-latency instruction memory, and presents the
//            {PC+4, instruction} pair to the IF/ID pipeline register. A
//            one-entry skid buffer absorbs a response that lands while decode
//            is stalled. Redirects are honoured even while a request is in
//            flight, in which case the in-flight response is discarded.
// Ports    : clk_i, rst_i (async, active-high)
//            stall_i          decode stall (also IF/ID Keep)
//            redirect_i       branch/jump taken
//            redirect_pc_i    redirect target, bits [1:0] forced to 00
//            imem_req_o       memory request
//            imem_addr_o      memory request address
//            imem_ready_i     memory response valid
//            imem_data_i      memory response word
//            pcp4_o / inst_o  offered PC+4 / instruction
//            valid_o          slot holds an instruction
//            flush_o          IF/ID Reset
//            fetch_cnt_o      instructions consumed downstream
// Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pcp4_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        flush_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_STALLED = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_addr_q, old_addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pcp4_q, skid_pcp4_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        consume;
  logic        accept;
  logic        unused_redirect_lsbs;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // A redirect flushes IF/ID, so the slot content is killed rather than
  // handed downstream on that edge.
  assign consume = valid_q & ~stall_i & ~redirect_i;
  assign accept  = ~valid_q | consume;

  // Request interface decodes state only; DISCARD keeps the old address on
  // the bus because an issued request may not be withdrawn.
  assign imem_req_o  = (state_q == S_REQ) || (state_q == S_DISCARD);
  assign imem_addr_o = (state_q == S_DISCARD) ? old_addr_q : pc_q;

  assign flush_o     = redirect_i | (~valid_q & ~stall_i);
  assign valid_o     = valid_q;
  assign inst_o      = inst_q;
  assign pcp4_o      = pcp4_q;
  assign fetch_cnt_o = fetch_cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    old_addr_d  = old_addr_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    pcp4_d      = pcp4_q;
    skid_inst_d = skid_inst_q;
    skid_pcp4_d = skid_pcp4_q;
    fetch_cnt_d = fetch_cnt_q;

    if (consume) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      valid_d     = 1'b0;
    end

    if (redirect_i) begin
      valid_d     = 1'b0;
      skid_inst_d = 32'd0;
      skid_pcp4_d = 32'd0;
      pc_d        = redirect_target;
      unique case (state_q)
        S_REQ: begin
          if (!imem_ready_i) begin
            old_addr_d = pc_q;
            state_d    = S_DISCARD;
          end else begin
            state_d    = S_REQ;
          end
        end
        // The outstanding response may retire on this same edge; in that
        // case nothing is left to discard.
        S_DISCARD: state_d = imem_ready_i ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ready_i) begin
            pc_d = pc_plus4;
            if (accept) begin
              valid_d = 1'b1;
              inst_d  = imem_data_i;
              pcp4_d  = pc_plus4;
            end else begin
              skid_inst_d = imem_data_i;
              skid_pcp4_d = pc_plus4;
              state_d     = S_STALLED;
            end
          end
        end
        S_STALLED: begin
          if (consume) begin
            valid_d = 1'b1;
            inst_d  = skid_inst_q;
            pcp4_d  = skid_pcp4_q;
            state_d = S_REQ;
          end
        end
        S_DISCARD: begin
          if (imem_ready_i) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      old_addr_q  <= RESET_PC;
      valid_q     <= 1'b0;
      inst_q      <= 32'd0;
      pcp4_q      <= 32'd0;
      skid_inst_q <= 32'd0;
      skid_pcp4_q <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      old_addr_q  <= old_addr_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      pcp4_q      <= pcp4_d;
      skid_inst_q <= skid_inst_d;
      skid_pcp4_q <= skid_pcp4_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Directed self-checking bench for if_fetch_unit. A behavioural
//            memory returns word == address after a programmable latency.
//            Instructions expected downstream are queued and compared when
//            the DUT hands a slot over (Valid=1, Stall=0, no Redirect).
//            A second instance with RESET_PC=0xFFFFFFFC covers PC wrap.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] rpc;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] data;
  logic [31:0] pcp4, inst, cnt;
  logic        valid, flush;

  logic        w_req;
  logic [31:0] w_addr, w_pcp4, w_inst, w_cnt;
  logic        w_valid, w_flush;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          mem_lat  = 1;
  int          mcnt     = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  assign data = addr;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(rpc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ready_i(ready), .imem_data_i(data), .pcp4_o(pcp4), .inst_o(inst),
    .valid_o(valid), .flush_o(flush), .fetch_cnt_o(cnt)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(rpc), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(1'b1), .imem_data_i(w_addr), .pcp4_o(w_pcp4), .inst_o(w_inst),
    .valid_o(w_valid), .flush_o(w_flush), .fetch_cnt_o(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    sb.push_back({a + 32'd4, a});
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Memory: ready rises in the mem_lat-th cycle of a request
  always @(posedge clk) begin
    #1;
    if (rst || !req) begin
      mcnt  = 0;
      ready = 1'b0;
    end else begin
      if (ready) mcnt = 0;
      mcnt++;
      ready = (mcnt >= mem_lat);
    end
  end

  // Scoreboard check at every hand-over to IF/ID
  always @(negedge clk) begin
    if (!rst && valid && !stall && !redirect) begin
      chk("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_inst", inst, e[31:0]);
        chk("sb_pcp4", pcp4, e[63:32]);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'd0; ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pcp4", pcp4, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd1);
    chk("rst_waddr", w_addr, 32'hFFFF_FFFC);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);

    // Baseline
    next(); rst = 1'b0;
    next(); @(negedge clk);
    chk("first_req", {31'd0, req}, 32'd1);
    chk("first_addr", addr, 32'd0);
    chk("first_valid", {31'd0, valid}, 32'd0);
    next(); @(negedge clk);
    chk("fill_inst", inst, 32'h0);
    chk("fill_pcp4", pcp4, 32'h4);
    chk("fill_addr", addr, 32'h4);
    chk("fill_flush", {31'd0, flush}, 32'd0);
    chk("wrap_pcp4", w_pcp4, 32'h0);
    chk("wrap_inst", w_inst, 32'hFFFF_FFFC);
    chk("wrap_addr", w_addr, 32'h0);
    next(); @(negedge clk);
    chk("b2_inst", inst, 32'h4);
    chk("b2_cnt", cnt, 32'd1);

    // Stall for three edges
    next(); stall = 1'b1; @(negedge clk);
    chk("st0_inst", inst, 32'h8);
    chk("st0_cnt", cnt, 32'd2);
    chk("st0_flush", {31'd0, flush}, 32'd0);
    next(); @(negedge clk);
    chk("st1_req", {31'd0, req}, 32'd0);
    chk("st1_inst", inst, 32'h8);
    chk("st1_flush", {31'd0, flush}, 32'd0);
    next(); @(negedge clk);
    chk("st2_req", {31'd0, req}, 32'd0);
    chk("st2_inst", inst, 32'h8);
    next(); stall = 1'b0; @(negedge clk);
    chk("st3_inst", inst, 32'h8);
    chk("st3_cnt", cnt, 32'd2);
    next(); @(negedge clk);
    chk("rel_inst", inst, 32'hC);
    chk("rel_pcp4", pcp4, 32'h10);
    chk("rel_addr", addr, 32'h10);
    chk("rel_cnt", cnt, 32'd3);
    mem_lat = 3;

    // Redirect in the first wait cycle of a 3-cycle access
    next(); redirect = 1'b1; rpc = 32'h0000_0103; @(negedge clk);
    chk("rd_inst", inst, 32'h10);
    chk("rd_cnt", cnt, 32'd4);
    chk("rd_flush", {31'd0, flush}, 32'd1);
    chk("rd_addr", addr, 32'h14);
    next(); redirect = 1'b0; @(negedge clk);
    chk("dis0_valid", {31'd0, valid}, 32'd0);
    chk("dis0_addr", addr, 32'h14);
    chk("dis0_req", {31'd0, req}, 32'd1);
    chk("dis0_flush", {31'd0, flush}, 32'd1);
    next(); @(negedge clk);
    chk("dis1_addr", addr, 32'h14);
    chk("dis1_flush", {31'd0, flush}, 32'd1);
    mem_lat = 1;
    push(32'h100);
    next(); @(negedge clk);
    chk("tgt_addr", addr, 32'h100);
    chk("tgt_valid", {31'd0, valid}, 32'd0);
    next(); @(negedge clk);
    chk("tgt_inst", inst, 32'h100);
    chk("tgt_pcp4", pcp4, 32'h104);
    chk("tgt_flush", {31'd0, flush}, 32'd0);

    // Redirect + Stall + ready together
    next(); stall = 1'b1; redirect = 1'b1; rpc = 32'h40; @(negedge clk);
    chk("sim_ready", {31'd0, ready}, 32'd1);
    chk("sim_flush", {31'd0, flush}, 32'd1);
    next(); stall = 1'b0; redirect = 1'b0; @(negedge clk);
    chk("sim_valid", {31'd0, valid}, 32'd0);
    chk("sim_addr", addr, 32'h40);
    chk("sim_flush2", {31'd0, flush}, 32'd1);
    push(32'h40);
    mem_lat = 4;
    next(); @(negedge clk);
    chk("sim_inst", inst, 32'h40);
    next(); @(negedge clk);
    chk("l4_valid", {31'd0, valid}, 32'd0);
    chk("l4_addr", addr, 32'h44);

    // Enter DISCARD, then reset asynchronously between edges
    next(); redirect = 1'b1; rpc = 32'h200; @(negedge clk);
    chk("d2_addr", addr, 32'h44);
    next(); redirect = 1'b0; @(negedge clk);
    chk("d2_hold", addr, 32'h44);
    chk("d2_req", {31'd0, req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, valid}, 32'd0);
    chk("ar_inst", inst, 32'd0);
    chk("ar_pcp4", pcp4, 32'd0);
    chk("ar_req", {31'd0, req}, 32'd0);
    chk("ar_cnt", cnt, 32'd0);
    chk("ar_addr", addr, 32'd0);
    mem_lat = 1;
    push(32'h0);
    @(posedge clk); #1 rst = 1'b0;
    next(); @(negedge clk);
    chk("ar_first_req", {31'd0, req}, 32'd1);
    chk("ar_first_addr", addr, 32'd0);
    chk("ar_waddr", w_addr, 32'hFFFF_FFFC);
    next(); @(negedge clk);
    chk("ar_fill_inst", inst, 32'h0);
    chk("ar_fill_cnt", cnt, 32'd0);
    chk("ar_wrap_pcp4", w_pcp4, 32'h0);
    chk("ar_wrap_addr", w_addr, 32'h0);
    next(); stall = 1'b1; @(negedge clk);
    chk("end_cnt", cnt, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
